note_track: RTL and testbench

Scrolling note lane for the rhythm game: accepts chart notes (red/blue) from the chart sequencer, scrolls them down an ROWS-deep track at a fixed tempo, and presents the judge row (node_R, node_B, offset) to the button judge. It consumes the judge's delete_note to remove hit notes. It reports un-hit notes leaving the judge row as misses. The full lane bitmaps drive the LED matrix renderer.

---
 rtl/note_track_if.sv | 30 +++
 rtl/note_track.sv | 156 +++++++++++++++
 tb/tb_note_track.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_track_if.sv
// Chart sequencer, button judge and LED renderer signals of one note lane.
// master = the surrounding game logic, slave = note_track.
`timescale 1ns/1ps
interface note_track_if #(
    parameter int ROWS = 8
);
    logic            start;
    logic            stop;
    logic            spawn_valid;
    logic [1:0]      spawn_color;
    logic            spawn_ready;
    logic            delete_note;
    logic            node_R;
    logic            node_B;
    logic [2:0]      offset;
    logic [ROWS-1:0] lane_R;
    logic [ROWS-1:0] lane_B;
    logic            miss;
    logic            busy;

    modport master (
        output start, stop, spawn_valid, spawn_color, delete_note,
        input  spawn_ready, node_R, node_B, offset, lane_R, lane_B, miss, busy
    );

    modport slave (
        input  start, stop, spawn_valid, spawn_color, delete_note,
        output spawn_ready, node_R, node_B, offset, lane_R, lane_B, miss, busy
    );
endinterface

// File: rtl/note_track.sv
// Scrolling red/blue note lane: one-entry intake buffer, ROWS-deep shift track, judge row and miss detection.
// Optional macro NOTE_TRACK_MISS_GRACE_EN: a delete in the cycle after a shift still cancels the departed row's miss.
`timescale 1ns/1ps
module note_track #(
    parameter int ROWS     = 8,
    parameter int TICK_DIV = 3125000
) (
    input  logic        clk,
    input  logic        rst,
    note_track_if.slave bus
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state_q,      state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [2:0]      offset_q,     offset_d;
    logic [ROWS-1:0] lane_r_q,     lane_r_d;
    logic [ROWS-1:0] lane_b_q,     lane_b_d;
    logic            pend_valid_q, pend_valid_d;
    logic [1:0]      pend_color_q, pend_color_d;
    logic            miss_q,       miss_d;
`ifdef NOTE_TRACK_MISS_GRACE_EN
    logic            post_shift_q, post_shift_d;
    logic            miss_cand_q,  miss_cand_d;
`endif

    logic active;
    logic tick;
    logic shift;
    logic row0_full;
    logic del_hit;
    logic row0_clear_ok;
    logic spawn_ready;
    logic accept;

    // NOTE: every state register, including the whole track, is reset; an
    // async rst mid-song must leave no stale notes or pending misses behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            offset_q     <= '0;
            lane_r_q     <= '0;
            lane_b_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_color_q <= '0;
            miss_q       <= 1'b0;
`ifdef NOTE_TRACK_MISS_GRACE_EN
            post_shift_q <= 1'b0;
            miss_cand_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q      <= state_d;
            div_q        <= div_d;
            offset_q     <= offset_d;
            lane_r_q     <= lane_r_d;
            lane_b_q     <= lane_b_d;
            pend_valid_q <= pend_valid_d;
            pend_color_q <= pend_color_d;
            miss_q       <= miss_d;
`ifdef NOTE_TRACK_MISS_GRACE_EN
            post_shift_q <= post_shift_d;
            miss_cand_q  <= miss_cand_d;
`endif
        end
    end

    always_comb begin
        active      = (state_q != S_IDLE);
        tick        = active && (div_q == DIV_W'(TICK_DIV - 1));
        shift       = tick && (offset_q == 3'd7);
        row0_full   = lane_r_q[0] | lane_b_q[0];
        del_hit     = bus.delete_note && active && row0_full;
        spawn_ready = (state_q == S_RUN) && !pend_valid_q;
        accept      = bus.spawn_valid && spawn_ready;
`ifdef NOTE_TRACK_MISS_GRACE_EN
        row0_clear_ok = !post_shift_q;
`else
        row0_clear_ok = 1'b1;
`endif

        // NOTE: defaults first so no path through this block infers a latch.
        state_d      = state_q;
        div_d        = div_q;
        offset_d     = offset_q;
        lane_r_d     = lane_r_q;
        lane_b_d     = lane_b_q;
        pend_valid_d = pend_valid_q;
        pend_color_d = pend_color_q;
        miss_d       = 1'b0;
`ifdef NOTE_TRACK_MISS_GRACE_EN
        post_shift_d = shift;
        miss_cand_d  = shift && row0_full && !del_hit;
        miss_d       = miss_cand_q && !(bus.delete_note && active);
`else
        miss_d       = shift && row0_full && !del_hit;
`endif

        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (bus.stop)  state_d = S_DRAIN;
            S_DRAIN: if ((lane_r_q == '0) && (lane_b_q == '0) && !pend_valid_q)
                         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) offset_d = offset_q + 3'd1;
        end

        if (shift) begin
            // Departing row 0 drops off; pending colour (or blank) enters the top.
            lane_r_d     = {pend_valid_q & pend_color_q[1], lane_r_q[ROWS-1:1]};
            lane_b_d     = {pend_valid_q & pend_color_q[0], lane_b_q[ROWS-1:1]};
            pend_valid_d = accept;
            pend_color_d = accept ? bus.spawn_color : pend_color_q;
        end else begin
            if (accept) begin
                pend_valid_d = 1'b1;
                pend_color_d = bus.spawn_color;
            end
            if (del_hit && row0_clear_ok) begin
                lane_r_d[0] = 1'b0;
                lane_b_d[0] = 1'b0;
            end
        end

        // Entering RUN and returning to IDLE both start from an empty lane.
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            div_d        = '0;
            offset_d     = '0;
            lane_r_d     = '0;
            lane_b_d     = '0;
            pend_valid_d = 1'b0;
            pend_color_d = '0;
        end
    end

    assign bus.spawn_ready = spawn_ready;
    assign bus.node_R      = lane_r_q[0];
    assign bus.node_B      = lane_b_q[0];
    assign bus.offset      = offset_q;
    assign bus.lane_R      = lane_r_q;
    assign bus.lane_B      = lane_b_q;
    assign bus.miss        = miss_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_note_track.sv
// Directed bench for note_track with ROWS=8, TICK_DIV=4 (row period 32 cycles).
// Cycle 0 is the first RUN cycle; a note accepted in cycle 0 reaches row 0 in cycle 256.
`timescale 1ns/1ps
module tb_note_track;
    localparam int ROWS     = 8;
    localparam int TICK_DIV = 4;
`ifdef NOTE_TRACK_MISS_GRACE_EN
    localparam int   MISS_LAT = 2;
    localparam logic GRACE    = 1'b1;
`else
    localparam int   MISS_LAT = 1;
    localparam logic GRACE    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    note_track_if #(.ROWS(ROWS)) bus ();

    note_track #(.ROWS(ROWS), .TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required normal completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic advance_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.spawn_valid = 1'b0;
        bus.spawn_color = 2'b00;
        bus.delete_note = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // start the song with the first note offered; optional second note accepted in cycle 32
    task automatic launch(input logic [1:0] c_first, input logic [1:0] c_second, input bit two);
        @(negedge clk);
        cyc             = -1;
        bus.start       = 1'b1;
        bus.spawn_valid = 1'b1;
        bus.spawn_color = c_first;
        advance_to(0);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL launch_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.spawn_ready !== 1'b1) begin errors++; $display("FAIL launch_ready: got %b expected 1", bus.spawn_ready); end
        advance_to(1);
        checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL launch_pending_ready: got %b expected 0", bus.spawn_ready); end
        if (two) bus.spawn_color = c_second;
        else     bus.spawn_valid = 1'b0;
        if (two) begin
            advance_to(33);
            bus.spawn_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.spawn_valid = 1'b0;
        bus.spawn_color = 2'b00;
        bus.delete_note = 1'b0;
        #1;
        checks++; if ({bus.spawn_ready, bus.node_R, bus.node_B, bus.miss, bus.busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.spawn_ready, bus.node_R, bus.node_B, bus.miss, bus.busy}); end
        checks++; if (bus.offset !== 3'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", bus.offset); end
        checks++; if ({bus.lane_R, bus.lane_B} !== 16'h0) begin errors++; $display("FAIL reset_lanes: got %h expected 0000", {bus.lane_R, bus.lane_B}); end
        @(negedge clk);
        rst = 1'b0;
        bus.spawn_valid = 1'b1;
        bus.spawn_color = 2'b10;
        repeat (6) @(negedge clk);
        checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", bus.spawn_ready); end
        checks++; if (bus.lane_R !== 8'h00) begin errors++; $display("FAIL idle_lane_R: got %h expected 00", bus.lane_R); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
        bus.spawn_valid = 1'b0;
    endtask

    task automatic test_single_miss();
        do_reset();
        launch(2'b10, 2'b00, 1'b0);
        advance_to(32);
        checks++; if (bus.lane_R !== 8'h80) begin errors++; $display("FAIL single_top_row: got %h expected 80", bus.lane_R); end
        advance_to(255);
        checks++; if (bus.lane_R !== 8'h02) begin errors++; $display("FAIL single_row1: got %h expected 02", bus.lane_R); end
        advance_to(256);
        checks++; if (bus.node_R !== 1'b1) begin errors++; $display("FAIL single_node_R: got %b expected 1", bus.node_R); end
        checks++; if (bus.offset !== 3'd0) begin errors++; $display("FAIL single_offset: got %0d expected 0", bus.offset); end
        advance_to(286 + MISS_LAT);
        checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL single_miss_early: got %b expected 0", bus.miss); end
        advance_to(287 + MISS_LAT);
        checks++; if (bus.miss !== 1'b1) begin errors++; $display("FAIL single_miss_pulse: got %b expected 1", bus.miss); end
        advance_to(288 + MISS_LAT);
        checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL single_miss_width: got %b expected 0", bus.miss); end
        checks++; if (bus.node_R !== 1'b0) begin errors++; $display("FAIL single_node_R_gone: got %b expected 0", bus.node_R); end
    endtask

    task automatic test_delete();
        do_reset();
        launch(2'b10, 2'b00, 1'b0);
        advance_to(268);
        checks++; if (bus.offset !== 3'd3) begin errors++; $display("FAIL delete_offset: got %0d expected 3", bus.offset); end
        checks++; if (bus.node_R !== 1'b1) begin errors++; $display("FAIL delete_before: got %b expected 1", bus.node_R); end
        bus.delete_note = 1'b1;
        advance_to(269);
        bus.delete_note = 1'b0;
        checks++; if (bus.node_R !== 1'b0) begin errors++; $display("FAIL delete_cleared: got %b expected 0", bus.node_R); end
        for (int c = 286; c <= 291; c++) begin
            advance_to(c);
            checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL delete_no_miss cycle %0d: got %b expected 0", c, bus.miss); end
        end
    endtask

    task automatic test_dual_rest();
        do_reset();
        launch(2'b11, 2'b00, 1'b1);
        advance_to(255);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b00) begin errors++; $display("FAIL dual_before: got %b expected 00", {bus.node_R, bus.node_B}); end
        advance_to(256);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b11) begin errors++; $display("FAIL dual_first: got %b expected 11", {bus.node_R, bus.node_B}); end
        advance_to(287);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b11) begin errors++; $display("FAIL dual_last: got %b expected 11", {bus.node_R, bus.node_B}); end
        advance_to(288);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b00) begin errors++; $display("FAIL rest_row: got %b expected 00", {bus.node_R, bus.node_B}); end
        advance_to(319);
        checks++; if ({bus.lane_R, bus.lane_B} !== 16'h0) begin errors++; $display("FAIL rest_lanes: got %h expected 0000", {bus.lane_R, bus.lane_B}); end
        advance_to(319 + MISS_LAT);
        checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL rest_no_miss: got %b expected 0", bus.miss); end
    endtask

    task automatic test_grace();
        do_reset();
        launch(2'b10, 2'b01, 1'b1);
        advance_to(287);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b10) begin errors++; $display("FAIL grace_departing: got %b expected 10", {bus.node_R, bus.node_B}); end
        advance_to(288);
        checks++; if ({bus.node_R, bus.node_B} !== 2'b01) begin errors++; $display("FAIL grace_incoming: got %b expected 01", {bus.node_R, bus.node_B}); end
        checks++; if (bus.miss !== ~GRACE) begin errors++; $display("FAIL grace_miss_288: got %b expected %b", bus.miss, ~GRACE); end
        bus.delete_note = 1'b1;
        advance_to(289);
        bus.delete_note = 1'b0;
        checks++; if (bus.miss !== 1'b0) begin errors++; $display("FAIL grace_miss_289: got %b expected 0", bus.miss); end
        checks++; if (bus.node_B !== GRACE) begin errors++; $display("FAIL grace_new_row0: got %b expected %b", bus.node_B, GRACE); end
        advance_to(319 + MISS_LAT);
        checks++; if (bus.miss !== GRACE) begin errors++; $display("FAIL grace_second_miss: got %b expected %b", bus.miss, GRACE); end
    endtask

    task automatic test_drain();
        do_reset();
        @(negedge clk);
        cyc             = -1;
        bus.start       = 1'b1;
        bus.spawn_valid = 1'b1;
        bus.spawn_color = 2'b10;
        advance_to(0);
        bus.start = 1'b0;
        advance_to(97);
        checks++; if (bus.lane_R !== 8'hE0) begin errors++; $display("FAIL drain_three_notes: got %h expected e0", bus.lane_R); end
        checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL drain_pending: got %b expected 0", bus.spawn_ready); end
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        advance_to(98);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b expected 1", bus.busy); end
        advance_to(128);
        checks++; if (bus.lane_R !== 8'hF0) begin errors++; $display("FAIL drain_pending_loaded: got %h expected f0", bus.lane_R); end
        checks++; if (bus.spawn_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b expected 0", bus.spawn_ready); end
        advance_to(150);
        bus.start = 1'b1;
        advance_to(151);
        bus.start = 1'b0;
        checks++; if (bus.lane_R !== 8'hF0) begin errors++; $display("FAIL drain_start_ignored: got %h expected f0", bus.lane_R); end
        advance_to(383);
        checks++; if (bus.node_R !== 1'b1) begin errors++; $display("FAIL drain_last_note: got %b expected 1", bus.node_R); end
        advance_to(384);
        checks++; if (bus.lane_R !== 8'h00) begin errors++; $display("FAIL drain_empty: got %h expected 00", bus.lane_R); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy_hold: got %b expected 1", bus.busy); end
        advance_to(385);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain_busy_fall: got %b expected 0", bus.busy); end
        advance_to(390);
        checks++; if ({bus.spawn_ready, bus.lane_R} !== 9'h0) begin errors++; $display("FAIL drain_idle: got %h expected 000", {bus.spawn_ready, bus.lane_R}); end
        bus.spawn_valid = 1'b0;
    endtask

    task automatic test_rst_drain();
        do_reset();
        @(negedge clk);
        cyc             = -1;
        bus.start       = 1'b1;
        bus.spawn_valid = 1'b1;
        bus.spawn_color = 2'b01;
        advance_to(0);
        bus.start = 1'b0;
        advance_to(40);
        bus.stop = 1'b1;
        advance_to(41);
        bus.stop        = 1'b0;
        bus.spawn_valid = 1'b0;
        advance_to(100);
        checks++; if (bus.lane_B !== 8'h60) begin errors++; $display("FAIL rst_pre_lane_B: got %h expected 60", bus.lane_B); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.lane_R, bus.lane_B} !== 16'h0) begin errors++; $display("FAIL rst_lanes: got %h expected 0000", {bus.lane_R, bus.lane_B}); end
        checks++; if ({bus.busy, bus.spawn_ready, bus.node_B, bus.miss, bus.offset} !== 7'h0) begin errors++; $display("FAIL rst_outputs: got %b expected 0000000", {bus.busy, bus.spawn_ready, bus.node_B, bus.miss, bus.offset}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({bus.busy, bus.miss, bus.lane_B} !== 10'h0) begin errors++; $display("FAIL rst_after: got %h expected 000", {bus.busy, bus.miss, bus.lane_B}); end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_delete();
        test_dual_rest();
        test_grace();
        test_drain();
        test_rst_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
